// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL timer block: prescaler widths and status bit layout.
package jtopl_pkg;

   localparam int PRE_A     = 2;
   localparam int PRE_B     = 4;

   localparam int ST_IRQ    = 7;
   localparam int ST_FLAG_A = 6;
   localparam int ST_FLAG_B = 5;

   // CPU-visible status byte built from the two timer flags.
   function automatic logic [7:0] pack_status(input logic fa, input logic fb);
      logic [7:0] st;
      st            = 8'h00;
      st[ST_IRQ]    = fa | fb;
      st[ST_FLAG_A] = fa;
      st[ST_FLAG_B] = fb;
      return st;
   endfunction

endpackage

// File: rtl/jtopl_timer_cnt.sv
// One 8-bit OPL timer: up-counter with reload on wrap, maskable sticky flag and overflow pulse.
module jtopl_timer_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       step,
   input  logic [7:0] value,
   input  logic       load,
   input  logic       flagen,
   input  logic       clr_flag,
   output logic       flag,
   output logic       overflow
);

   logic [7:0] cnt;
   logic       run;
   logic       start;
   logic       advance;
   logic       wrap;

   // start and wrap are mutually exclusive: start needs run low, wrap needs run high
   assign start   = load & ~run;
   assign advance = step & run & load;
   assign wrap    = advance & (cnt == 8'hFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= 8'h00;
         run      <= 1'b0;
         flag     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         run <= load;
         if (start)
            cnt <= value;
         else if (advance)
            cnt <= wrap ? value : cnt + 8'd1;
         // an overflow landing on a clear cycle must not be lost
         if (wrap & flagen)
            flag <= 1'b1;
         else if (clr_flag)
            flag <= 1'b0;
         if (tick)
            overflow <= wrap;
      end
   end

endmodule

// File: rtl/jtopl_timers.sv
// Dual OPL timer block: shared sample prescaler, Timer A/B step strobes, status and IRQ.
module jtopl_timers #(
   parameter int PRE_A = jtopl_pkg::PRE_A,
   parameter int PRE_B = jtopl_pkg::PRE_B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cenop,
   input  logic       zero,
   input  logic [7:0] value_A,
   input  logic [7:0] value_B,
   input  logic       load_A,
   input  logic       load_B,
   input  logic       flagen_A,
   input  logic       flagen_B,
   input  logic       clr_flag_A,
   input  logic       clr_flag_B,
   output logic       flag_A,
   output logic       flag_B,
   output logic       overflow_A,
   output logic       irq_n,
   output logic [7:0] status
);

   import jtopl_pkg::*;

   logic [PRE_B-1:0] pre;
   logic             tick;
   logic             step_a;
   logic             step_b;
   logic             unused_ovf_b;

   assign tick   = cenop & zero;
   assign step_a = tick & (&pre[PRE_A-1:0]);
   assign step_b = tick & (&pre);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pre <= '0;
      else if (tick)
         pre <= pre + 1'b1;
   end

   jtopl_timer_cnt u_timer_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .step     (step_a),
      .value    (value_A),
      .load     (load_A),
      .flagen   (flagen_A),
      .clr_flag (clr_flag_A),
      .flag     (flag_A),
      .overflow (overflow_A)
   );

   // Timer B overflow has no consumer downstream
   jtopl_timer_cnt u_timer_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .step     (step_b),
      .value    (value_B),
      .load     (load_B),
      .flagen   (flagen_B),
      .clr_flag (clr_flag_B),
      .flag     (flag_B),
      .overflow (unused_ovf_b)
   );

   assign irq_n  = ~(flag_A | flag_B);
   assign status = pack_status(flag_A, flag_B);

endmodule

// File: tb/tb_jtopl_timers.sv
// Self-checking bench for jtopl_timers: directed period/flag scenarios plus randomized model comparison.
module tb_jtopl_timers;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cenop = 1'b0, zero = 1'b0;
   logic [7:0] value_A = 8'h00, value_B = 8'h00;
   logic       load_A = 1'b0, load_B = 1'b0;
   logic       flagen_A = 1'b0, flagen_B = 1'b0;
   logic       clr_flag_A = 1'b0, clr_flag_B = 1'b0;
   logic       flag_A, flag_B, overflow_A, irq_n;
   logic [7:0] status;

   int total = 0;
   int bad   = 0;

   jtopl_timers dut (
      .clk(clk), .rst_n(rst_n), .cenop(cenop), .zero(zero),
      .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
      .flagen_A(flagen_A), .flagen_B(flagen_B),
      .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
      .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
      .irq_n(irq_n), .status(status)
   );

   always #5 clk = ~clk;

   // Reference: sample-tick count, and per timer the number of steps left before it wraps.
   int   m_ticks;
   int   m_rem[2];
   logic m_run[2];
   logic m_flag[2];
   logic m_ovf_a;

   task automatic model_reset();
      m_ticks = 0;
      m_ovf_a = 1'b0;
      for (int t = 0; t < 2; t++) begin
         m_rem[t]  = 256;
         m_run[t]  = 1'b0;
         m_flag[t] = 1'b0;
      end
   endtask

   task automatic model_clock();
      logic       tk, ld, fe, cl;
      logic [7:0] val;
      logic       st[2];
      logic       ov[2];
      if (!rst_n) begin
         model_reset();
         return;
      end
      tk    = cenop && zero;
      st[0] = tk && ((m_ticks % 4) == 3);
      st[1] = tk && ((m_ticks % 16) == 15);
      for (int t = 0; t < 2; t++) begin
         ld  = (t == 0) ? load_A : load_B;
         val = (t == 0) ? value_A : value_B;
         fe  = (t == 0) ? flagen_A : flagen_B;
         cl  = (t == 0) ? clr_flag_A : clr_flag_B;
         ov[t] = 1'b0;
         if (ld && !m_run[t]) begin
            m_rem[t] = 256 - int'(val);
         end else if (ld && st[t]) begin
            m_rem[t] = m_rem[t] - 1;
            if (m_rem[t] == 0) begin
               ov[t]    = 1'b1;
               m_rem[t] = 256 - int'(val);
            end
         end
         if (ov[t] && fe)
            m_flag[t] = 1'b1;
         else if (cl)
            m_flag[t] = 1'b0;
         m_run[t] = ld;
      end
      if (tk) begin
         m_ovf_a = ov[0];
         m_ticks = m_ticks + 1;
      end
   endtask

   task automatic clk_cycle(input logic ce, input logic z);
      cenop = ce;
      zero  = z;
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) clk_cycle(1'b1, 1'b1);
   endtask

   task automatic apply_reset();
      load_A = 0; load_B = 0; flagen_A = 0; flagen_B = 0;
      clr_flag_A = 0; clr_flag_B = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      clk_cycle(0, 0);
      clk_cycle(0, 0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int seen;
      apply_reset();
      total++;
      if (flag_A !== 1'b0 || flag_B !== 1'b0 || irq_n !== 1'b1 || status !== 8'h00) begin
         bad++;
         $display("FAIL reset_values: flags=%b%b irq_n=%b status=%h, required 00 1 00",
                  flag_A, flag_B, irq_n, status);
      end
      value_A = 8'hFF; flagen_A = 1; load_A = 1;
      clk_cycle(0, 0);
      ticks(4);
      total++;
      if (flag_A !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_flag: flag_A=%b required 1", flag_A);
      end
      #2;
      rst_n  = 1'b0;
      load_A = 1'b0;
      model_reset();
      #1;
      total++;
      if (flag_A !== 1'b0 || irq_n !== 1'b1 || status !== 8'h00 || overflow_A !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: flag_A=%b irq_n=%b status=%h ovf=%b, required 0 1 00 0",
                  flag_A, irq_n, status, overflow_A);
      end
      clk_cycle(0, 0);
      clk_cycle(0, 0);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         ticks(1);
         if (overflow_A || flag_A) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL no_step_after_reset: events=%0d required 0", seen);
      end
      load_A = 1;
      clk_cycle(0, 0);
      ticks(4);
      total++;
      if (flag_A !== 1'b1) begin
         bad++;
         $display("FAIL restart_after_reset: flag_A=%b required 1", flag_A);
      end
   endtask

   task automatic test_timer_a_period();
      int n;
      apply_reset();
      value_A = 8'hFC; flagen_A = 1; load_A = 1;
      clk_cycle(0, 0);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         ticks(1);
         if (flag_A === 1'b1) begin
            n = i;
            break;
         end
      end
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL timer_a_period: ticks=%0d required 16", n);
      end
      total++;
      if (overflow_A !== 1'b1 || irq_n !== 1'b0 || status !== 8'hC0) begin
         bad++;
         $display("FAIL timer_a_outputs: ovf=%b irq_n=%b status=%h, required 1 0 c0",
                  overflow_A, irq_n, status);
      end
      ticks(1);
      total++;
      if (overflow_A !== 1'b0) begin
         bad++;
         $display("FAIL ovf_width: ovf=%b required 0", overflow_A);
      end
      clr_flag_A = 1;
      clk_cycle(0, 0);
      clr_flag_A = 0;
      total++;
      if (flag_A !== 1'b0 || irq_n !== 1'b1) begin
         bad++;
         $display("FAIL clear_latency: flag_A=%b irq_n=%b required 0 1", flag_A, irq_n);
      end
   endtask

   task automatic test_timer_b_period();
      int n;
      apply_reset();
      value_B = 8'hFE; flagen_B = 1; load_B = 1;
      clk_cycle(0, 0);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         ticks(1);
         if (flag_B === 1'b1) begin
            n = i;
            break;
         end
      end
      total++;
      if (n != 32) begin
         bad++;
         $display("FAIL timer_b_period: ticks=%0d required 32", n);
      end
      total++;
      if (status !== 8'hA0 || flag_A !== 1'b0 || irq_n !== 1'b0) begin
         bad++;
         $display("FAIL timer_b_outputs: status=%h flag_A=%b irq_n=%b required a0 0 0",
                  status, flag_A, irq_n);
      end
   endtask

   task automatic test_masked();
      logic exp;
      apply_reset();
      flagen_A = 0; value_A = 8'hFF; load_A = 1;
      clk_cycle(0, 0);
      for (int i = 1; i <= 16; i++) begin
         ticks(1);
         exp = ((i % 4) == 0);
         total++;
         if (overflow_A !== exp) begin
            bad++;
            $display("FAIL masked_ovf tick %0d: ovf=%b required %b", i, overflow_A, exp);
         end
      end
      total++;
      if (flag_A !== 1'b0 || irq_n !== 1'b1) begin
         bad++;
         $display("FAIL masked_flag: flag_A=%b irq_n=%b required 0 1", flag_A, irq_n);
      end
   endtask

   task automatic test_set_beats_clear();
      apply_reset();
      value_A = 8'hFF; flagen_A = 1; load_A = 1;
      clk_cycle(0, 0);
      clr_flag_A = 1;
      ticks(3);
      total++;
      if (flag_A !== 1'b0) begin
         bad++;
         $display("FAIL pre_overflow_flag: flag_A=%b required 0", flag_A);
      end
      ticks(1);
      total++;
      if (flag_A !== 1'b1) begin
         bad++;
         $display("FAIL set_wins: flag_A=%b required 1", flag_A);
      end
      clk_cycle(0, 0);
      clr_flag_A = 0;
      total++;
      if (flag_A !== 1'b0) begin
         bad++;
         $display("FAIL clear_after_set: flag_A=%b required 0", flag_A);
      end
   endtask

   task automatic test_stop_restart();
      int seen, n;
      apply_reset();
      value_A = 8'hFC; flagen_A = 1; load_A = 1;
      clk_cycle(0, 0);
      ticks(8);
      load_A = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         ticks(1);
         if (overflow_A || flag_A) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL stopped_holds: events=%0d required 0", seen);
      end
      value_A = 8'h80; load_A = 1;
      clk_cycle(0, 0);
      n = -1;
      for (int i = 1; i <= 700; i++) begin
         ticks(1);
         if (flag_A === 1'b1) begin
            n = i;
            break;
         end
      end
      total++;
      if (n != 512) begin
         bad++;
         $display("FAIL restart_period: ticks=%0d required 512", n);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_st;
      int         shown;
      logic [7:0] pick;
      apply_reset();
      shown = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 63) == 0) load_A = ~load_A;
         if ($urandom_range(0, 63) == 0) load_B = ~load_B;
         if ($urandom_range(0, 31) == 0) flagen_A = ~flagen_A;
         if ($urandom_range(0, 31) == 0) flagen_B = ~flagen_B;
         if ($urandom_range(0, 15) == 0) begin
            pick = 8'($urandom);
            value_A = ($urandom_range(0, 1) == 1) ? (8'hF8 | pick) : pick;
         end
         if ($urandom_range(0, 15) == 0) begin
            pick = 8'($urandom);
            value_B = ($urandom_range(0, 1) == 1) ? (8'hFC | pick) : pick;
         end
         clr_flag_A = ($urandom_range(0, 15) == 0);
         clr_flag_B = ($urandom_range(0, 15) == 0);
         clk_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
         exp_st = {m_flag[0] | m_flag[1], m_flag[0], m_flag[1], 5'b0};
         total++;
         if (flag_A !== m_flag[0] || flag_B !== m_flag[1] || overflow_A !== m_ovf_a ||
             irq_n !== ~(m_flag[0] | m_flag[1]) || status !== exp_st) begin
            bad++;
            if (shown < 10)
               $display("FAIL random cycle %0d: fa=%b fb=%b ovf=%b irq_n=%b st=%h, required %b %b %b %b %h",
                        i, flag_A, flag_B, overflow_A, irq_n, status,
                        m_flag[0], m_flag[1], m_ovf_a, ~(m_flag[0] | m_flag[1]), exp_st);
            shown++;
         end
      end
      clr_flag_A = 0;
      clr_flag_B = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_timer_a_period();
      test_timer_b_period();
      test_masked();
      test_set_beats_clear();
      test_stop_restart();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtopl_timers.md
# jtopl_timers

Dual OPL timer block (Timer A 80 µs, Timer B 320 µs). It sits directly downstream of the register map and consumes its timer outputs: `value_A/B`, `load_A/B`, `flagen_A/B` and `clr_flag_A/B`. It produces the `flag_A` and `overflow_A` signals that the register map takes back in, plus the status flags and the interrupt line seen by the CPU. It is clocked by `clk`, advances only on sample ticks derived from `cenop` and `zero`, and is the only sequential owner of the timer counters.

## Interface
Parameters:
- `PRE_A`, default 2: log2 of samples per Timer A tick (4 samples).
- `PRE_B`, default 4: log2 of samples per Timer B tick (16 samples).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cenop`  in  1: operator clock enable from the divider.
- `zero`  in  1: slot-0 marker. A sample tick is `cenop & zero`.
- `value_A`  in  8: Timer A preset.
- `value_B`  in  8: Timer B preset.
- `load_A`  in  1: level, Timer A run enable.
- `load_B`  in  1: level, Timer B run enable.
- `flagen_A`  in  1: Timer A flag enable (a 0 masks the flag).
- `flagen_B`  in  1: Timer B flag enable (a 0 masks the flag).
- `clr_flag_A`  in  1: clears flag A; may be held for several `clk` cycles.
- `clr_flag_B`  in  1: clears flag B; may be held for several `clk` cycles.
- `flag_A`  out  1: Timer A status flag.
- `flag_B`  out  1: Timer B status flag.
- `overflow_A`  out  1: one-sample-tick pulse on Timer A wrap (used later for CSM key-on).
- `irq_n`  out  1: active-low interrupt, equal to `~(flag_A | flag_B)`.
- `status`  out  8: `{flag_A|flag_B, flag_A, flag_B, 5'b0}`.

## Operation
- **Prescaler:** a free-running PRE_B-bit sample counter `pre` increments on each sample tick.
  - Timer A steps on a tick when `pre[PRE_A-1:0]` is all ones.
  - Timer B steps on a tick when `pre` is all ones.
- **Per-timer state:** 8-bit counter `cnt`, `run` (the registered copy of `load`), and `flag`.
- **Start:** on a `load` 0→1 edge, sampled at any `clk`, `cnt` is set to `value` and the timer is RUNNING. The first step can occur at the next qualifying tick.
- **Stop:** with `load` at 0 the timer is STOPPED and `cnt` holds.
- **Counting:** when RUNNING, each step does `cnt <= cnt + 1`.
  - When `cnt` is 8'hFF, a step instead reloads `value` (the current input, not the value latched at start) and raises overflow.
- **Flag set:** on overflow, `flag` is set if `flagen` is 1. With `flagen` at 0 the counter still wraps and `overflow_A` still pulses.
- **Flag clear:** `clr_flag` at 1 clears `flag` on every `clk` where it is high.
- **Simultaneous set and clear:** if an overflow-set and `clr_flag` fall in the same cycle, set wins, so no event is lost.
- **Clearing `flagen`:** taking `flagen` from 1 to 0 does not clear an already-set flag.
- **Load edge with a step:** a `load` 0→1 edge in the same cycle as a step gives reload priority (`cnt = value`, no increment).
- **Reset:** mid-operation reset forces all state to reset values asynchronously. Counting restarts only after `rst_n` is released and a fresh `load` edge occurs.

## Timing
- **Reset values:**
  - `flag_A`, `flag_B`, `overflow_A` = 0.
  - `irq_n` = 1, `status` = 8'h00.
  - `cnt` = 0, `run` = 0, `pre` = 0.
- **Period:** a timer with preset V overflows every `(256−V)·2^PRE` sample ticks. V = 8'hFF therefore overflows on every step.
- **Flag latency:** `flag` rises on the `clk` edge that samples the overflowing tick.
- **Interrupt and status latency:** `irq_n` and `status` are combinational from the flags (zero extra latency).
- **`overflow_A` width:** high from the overflowing tick edge until the next sample-tick edge, i.e. one sample.
- **Clear latency:** `clr_flag` takes effect in 1 `clk`.
- **Gating:** `cenop` low or `zero` low means no counter or prescaler change. Load edges and flag clears act regardless.

## Structure
- Sub-module `jtopl_timer_cnt`: one 8-bit timer (count, reload, flag, overflow), instantiated twice and fed separate step strobes.
  - Timer B's overflow output is left unconnected.
- Shared package `jtopl_pkg`:
  - constants `PRE_A` = 2 and `PRE_B` = 4;
  - status bit positions: IRQ = 7, FLAG_A = 6, FLAG_B = 5.
- Top level holds the prescaler, the step-strobe generation and the status/interrupt assembly.

## Test plan
- **Reset:** assert `rst_n`=0 mid-count with `flag_A`=1. Required: `flag_A`=0, `irq_n`=1 and `status`=8'h00 immediately; no steps until a new `load_A` edge.
- **Timer A period:** `value_A`=8'hFC, `load_A`↑, `flagen_A`=1. Required: first `flag_A` after exactly 16 sample ticks (aligned to the prescaler); `overflow_A` pulses for 1 sample; `irq_n`=0; `status`=8'hC0.
- **Timer B period:** `value_B`=8'hFE, `load_B`↑. Required: `flag_B` after exactly 32 ticks; `status`=8'hA0; `flag_A` unaffected.
- **Masked timer:** `flagen_A`=0, `value_A`=8'hFF. Required: `overflow_A` pulses every 4 ticks; `flag_A` stays 0; `irq_n` stays 1.
- **Set beats clear:** hold `clr_flag_A`=1 across an overflow tick. Required: `flag_A`=1 after that cycle; it clears on the next `clr_flag_A` cycle with no overflow.
- **Stop and restart:** drop `load_A` mid-count; `cnt` holds. Required: re-raising `load_A` with `value_A`=8'h80 restarts from 8'h80 and overflows after 128·4 ticks.
